ec_scalar_mult_ctrl: RTL and testbench
======================================

Name: ec_scalar_mult_ctrl

Overview:
- Sequences the GF(2^7) point-addition datapath to compute Q = k·P by left-to-right double-and-add over a 7-bit scalar.
- Owns all point-at-infinity and degenerate cases (P+P, P+(−P), doubling with x=0), so the adder only ever receives generic operands.
- Talks to the adder/doubler over a req/ack operand interface.
- Sits between the crypto top level (start/done) and the point arithmetic unit.

Parameters:
- FW, 7, field element width; point = {x[FW-1:0], y[FW-1:0]}.
- KW, 7, scalar width.
- WAIT_LIMIT, 64, maximum cycles waiting for op_ack before abort.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a multiplication; sampled only in IDLE.
- scalar  in  KW  k, latched on accepted start.
- base  in  2*FW  P = {x,y}, latched on accepted start; never infinity.
- busy  out  1  high from the cycle after an accepted start until DONE exits.
- done  out  1  one-cycle pulse when result is valid.
- error  out  1  sticky abort flag; cleared by the next accepted start.
- result  out  2*FW  Q = {x,y}; held until the next done.
- result_inf  out  1  Q is the point at infinity.
- op_req  out  1  operation request to the adder.
- op_double  out  1  1 = doubling (op_a = op_b), 0 = add.
- op_a  out  2*FW  first operand.
- op_b  out  2*FW  second operand.
- op_ack  in  1  adder result valid this cycle.
- op_sum  in  2*FW  adder result, sampled when op_ack = 1.

Behaviour:
- Reset (async, rst_n = 0):
  - State → IDLE.
  - All outputs 0, including result, result_inf and error.
  - Internal R, R_inf and index cleared.
  - Reset mid-operation abandons the job; op_req drops immediately.
- States: IDLE, DBL_CHK, DBL_WAIT, ADD_CHK, ADD_WAIT, NEXT, DONE.
- IDLE: on start → latch k and P; R_inf = 1; i = KW-1; error = 0; go to DBL_CHK. Start is ignored in every other state.
- DBL_CHK (1 cycle):
  - If R_inf, or R.x == 0 → R_inf = 1; go to ADD_CHK. No request.
  - Else → DBL_WAIT.
- DBL_WAIT:
  - Drives op_req = 1, op_double = 1, op_a = op_b = R, all stable.
  - On op_ack: R ← op_sum; go to ADD_CHK.
- ADD_CHK (1 cycle):
  - k[i] == 0 → NEXT.
  - R_inf → R = P, R_inf = 0 → NEXT.
  - R.x == P.x and R.y == P.y → treated as doubling: if P.x == 0 → R_inf = 1, NEXT; else ADD_WAIT with op_double = 1, op_a = op_b = R.
  - R.x == P.x and R.y ≠ P.y (R = −P) → R_inf = 1 → NEXT.
  - Otherwise → ADD_WAIT with op_double = 0, op_a = R, op_b = P.
- ADD_WAIT: op_req = 1 with the operands above; on op_ack: R ← op_sum, R_inf = 0; go to NEXT.
- NEXT: if i == 0 → DONE; else i ← i−1 → DBL_CHK.
- DONE: result ← R, result_inf ← R_inf; done = 1 for one cycle; → IDLE.
- Handshake rules:
  - op_req and the operands are decoded from the registered state only (glitch-free).
  - Operands are stable while op_req = 1.
  - op_req falls the cycle after op_ack. Always ≥1 low cycle between requests.
  - op_ack outside the WAIT states is ignored.
- Latency:
  - A bit with both ops and ack in the first wait cycle takes 5 cycles.
  - A skipped op saves 1 cycle.
  - start→done with k = 0 is 3·KW + 1 = 22 cycles.
- Watchdog:
  - Counter clears on entry to a WAIT state.
  - On reaching WAIT_LIMIT without ack: op_req → 0, error = 1, result_inf = 1 → DONE (done still pulses).

Decomposition:
- Package ec_pkg holds:
  - FW, KW, POINT_W = 2*FW.
  - State enum.
  - Functions pt_x()/pt_y() to extract fields from {x,y}.
  - Function pt_is_neg(a,b): same x, different y.
- Natural sub-module ec_point_cmp: combinational comparison of R and P producing eq_x, eq_y and x_zero, used by DBL_CHK/ADD_CHK.

Test Plan:
1. scalar = 0, base = 14'h0A55 → no op_req ever; done at cycle 22 after start; result_inf = 1.
2. scalar = 1, base = 14'h0A55 → no op_req; result = 14'h0A55, result_inf = 0.
3. scalar = 2, base = 14'h0A55, responder acks after 3 cycles with 14'h1234 → exactly one request (op_double = 1, op_a = op_b = 14'h0A55); result = 14'h1234.
4. scalar = 3, base = 14'h0A55:
   - Responder returns 14'h0A41 for the double (−P: y = 0x55 ^ 0x14).
   - Then no add request is issued; result_inf = 1.
   - Repeat with double returning 14'h1234 → add request op_a = 14'h1234, op_b = 14'h0A55.
5. base = 14'h0055 (x = 0), scalar = 2 → doubling skipped, no op_req, result_inf = 1. Also assert start while busy → ignored, busy unchanged.
6. Abort cases:
   - op_ack tied 0, scalar = 2 → error = 1 and done after 64 wait cycles.
   - rst_n pulsed low during DBL_WAIT → op_req, busy and done go 0 asynchronously; next start runs cleanly.

Source files
------------

// File: rtl/ec_scalar_mult_ctrl_pkg.sv
// Shared types for the GF(2^7) scalar-multiply controller: widths, FSM encodings, point field helpers.
// Pure definitions; no latency or backpressure of its own.
package ec_pkg;
    localparam int FW      = 7;
    localparam int KW      = 7;
    localparam int POINT_W = 2 * FW;

    typedef logic [FW-1:0]      fe_t;
    typedef logic [POINT_W-1:0] pt_t;
    typedef logic [2:0]         state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_DBL_CHK  = 3'd1;
    localparam state_t ST_DBL_WAIT = 3'd2;
    localparam state_t ST_ADD_CHK  = 3'd3;
    localparam state_t ST_ADD_WAIT = 3'd4;
    localparam state_t ST_NEXT     = 3'd5;
    localparam state_t ST_DONE     = 3'd6;

    function automatic fe_t pt_x(input pt_t pt);
        return pt[POINT_W-1:FW];
    endfunction

    function automatic fe_t pt_y(input pt_t pt);
        return pt[FW-1:0];
    endfunction

    // In characteristic 2, -P shares x with P and differs in y.
    function automatic logic pt_is_neg(input pt_t a, input pt_t b);
        return (pt_x(a) == pt_x(b)) && (pt_y(a) != pt_y(b));
    endfunction
endpackage

// File: rtl/ec_scalar_mult_ctrl_if.sv
// Operand req/ack channel between the scalar-multiply controller and the point adder/doubler.
// Request holds with stable operands until ack; ack outside a request is ignored.
interface ec_scalar_mult_ctrl_if;
    import ec_pkg::*;

    logic op_req;
    logic op_double;
    pt_t  op_a;
    pt_t  op_b;
    logic op_ack;
    pt_t  op_sum;

    modport master (output op_req, op_double, op_a, op_b, input op_ack, op_sum);
    modport slave  (input op_req, op_double, op_a, op_b, output op_ack, op_sum);
endinterface

// File: rtl/ec_scalar_mult_ctrl_point_cmp.sv
// Combinational compare of accumulator R against base P for the degenerate-case checks.
// Zero latency; no handshake.
module ec_point_cmp
    import ec_pkg::*;
(
    input  pt_t  r,
    input  pt_t  p,
    output logic eq_x,
    output logic eq_y,
    output logic x_zero
);
    assign eq_x   = (pt_x(r) == pt_x(p));
    assign eq_y   = (pt_y(r) == pt_y(p));
    assign x_zero = (pt_x(r) == '0);
endmodule

// File: rtl/ec_scalar_mult_ctrl.sv
// Left-to-right double-and-add Q = k*P over GF(2^7); 3 cycles per bit plus 1 per issued op and ack wait.
// Stalls in WAIT until op_ack; a watchdog aborts with error after WAIT_LIMIT cycles.
module ec_scalar_mult_ctrl
    import ec_pkg::*;
#(
    parameter int WAIT_LIMIT = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [KW-1:0]               scalar,
    input  pt_t                         base,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output pt_t                         result,
    output logic                        result_inf,
    ec_scalar_mult_ctrl_if.master       op
);
    localparam int WDW   = $clog2(WAIT_LIMIT + 1);
    localparam int IDX_W = $clog2(KW);

    state_t           state;
    logic [KW-1:0]    k;
    pt_t              p;
    pt_t              r;
    logic             r_inf;
    logic [IDX_W-1:0] idx;
    logic [WDW-1:0]   wdog;
    logic             add_dbl;
    logic             eq_x, eq_y, x_zero;
    logic             in_wait;
    logic             wdog_hit;

    ec_point_cmp u_cmp (
        .r      (r),
        .p      (p),
        .eq_x   (eq_x),
        .eq_y   (eq_y),
        .x_zero (x_zero)
    );

    // Everything facing the adder is decoded from registered state only.
    assign in_wait      = (state == ST_DBL_WAIT) || (state == ST_ADD_WAIT);
    assign op.op_req    = in_wait;
    assign op.op_double = (state == ST_DBL_WAIT) || ((state == ST_ADD_WAIT) && add_dbl);
    assign op.op_a      = in_wait ? r : '0;
    assign op.op_b      = !in_wait ? '0 : (op.op_double ? r : p);
    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_DONE);
    assign wdog_hit     = (wdog == WDW'(WAIT_LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            k          <= '0;
            p          <= '0;
            r          <= '0;
            r_inf      <= 1'b0;
            idx        <= '0;
            wdog       <= '0;
            add_dbl    <= 1'b0;
            error      <= 1'b0;
            result     <= '0;
            result_inf <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        k     <= scalar;
                        p     <= base;
                        r_inf <= 1'b1;
                        idx   <= IDX_W'(KW - 1);
                        error <= 1'b0;
                        state <= ST_DBL_CHK;
                    end
                end
                ST_DBL_CHK: begin
                    if (r_inf || x_zero) begin
                        r_inf <= 1'b1;
                        state <= ST_ADD_CHK;
                    end else begin
                        wdog  <= '0;
                        state <= ST_DBL_WAIT;
                    end
                end
                ST_DBL_WAIT, ST_ADD_WAIT: begin
                    if (op.op_ack) begin
                        r     <= op.op_sum;
                        r_inf <= 1'b0;
                        state <= (state == ST_DBL_WAIT) ? ST_ADD_CHK : ST_NEXT;
                    end else if (wdog_hit) begin
                        error      <= 1'b1;
                        result     <= r;
                        result_inf <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ST_ADD_CHK: begin
                    if (!k[idx]) begin
                        state <= ST_NEXT;
                    end else if (r_inf) begin
                        r     <= p;
                        r_inf <= 1'b0;
                        state <= ST_NEXT;
                    end else if (eq_x && eq_y) begin
                        // R == P: the add degenerates to a doubling of P.
                        if (x_zero) begin
                            r_inf <= 1'b1;
                            state <= ST_NEXT;
                        end else begin
                            add_dbl <= 1'b1;
                            wdog    <= '0;
                            state   <= ST_ADD_WAIT;
                        end
                    end else if (pt_is_neg(r, p)) begin
                        r_inf <= 1'b1;
                        state <= ST_NEXT;
                    end else begin
                        add_dbl <= 1'b0;
                        wdog    <= '0;
                        state   <= ST_ADD_WAIT;
                    end
                end
                ST_NEXT: begin
                    if (idx == '0) begin
                        result     <= r;
                        result_inf <= r_inf;
                        state      <= ST_DONE;
                    end else begin
                        idx   <= idx - 1'b1;
                        state <= ST_DBL_CHK;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ec_scalar_mult_ctrl.sv
// Directed bench for ec_scalar_mult_ctrl with a scripted adder responder.
module tb_ec_scalar_mult_ctrl;
    import ec_pkg::*;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [KW-1:0] scalar;
    pt_t           base;
    logic          busy, done, error, result_inf;
    pt_t           result;

    ec_scalar_mult_ctrl_if opif();

    ec_scalar_mult_ctrl #(.WAIT_LIMIT(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .scalar     (scalar),
        .base       (base),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .result     (result),
        .result_inf (result_inf),
        .op         (opif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scripted adder: acks after resp_delay extra wait cycles, returns queued sums.
    int   req_cnt, req_hi, wait_cyc, resp_delay, stab_err;
    bit   ack_off;
    pt_t  resp_q[$];
    pt_t  req_a[$];
    pt_t  req_b[$];
    bit   req_dbl[$];
    pt_t  last_a, last_b;

    always @(negedge clk) begin
        opif.op_ack = 1'b0;
        if (opif.op_req) begin
            req_hi++;
            if (wait_cyc == 0) begin
                req_cnt++;
                req_a.push_back(opif.op_a);
                req_b.push_back(opif.op_b);
                req_dbl.push_back(opif.op_double);
            end else if (opif.op_a !== last_a || opif.op_b !== last_b) begin
                stab_err++;
            end
            last_a = opif.op_a;
            last_b = opif.op_b;
            if (!ack_off && wait_cyc == resp_delay) begin
                opif.op_ack = 1'b1;
                opif.op_sum = (resp_q.size() > 0) ? resp_q.pop_front() : '0;
                wait_cyc = 0;
            end else begin
                wait_cyc++;
            end
        end else begin
            wait_cyc = 0;
        end
    end

    task automatic kick(input logic [KW-1:0] k, input pt_t b);
        @(negedge clk);
        req_cnt = 0; req_hi = 0; wait_cyc = 0; stab_err = 0;
        req_a.delete(); req_b.delete(); req_dbl.delete();
        scalar = k; base = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input bit poke, output int cyc);
        bit got;
        got = 0;
        cyc = 0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 5) begin
                start = 1'b1; scalar = 7'h7F;
            end else if (poke && cyc == 6) begin
                start = 1'b0;
                chk("busy_during_start", busy, 1);
            end
            if (done) got = 1;
        end
        if (!got) chk("done_timeout", 0, 1);
    endtask

    int cyc;

    initial begin
        rst_n = 1'b0; start = 1'b0; scalar = '0; base = '0;
        opif.op_ack = 1'b0; opif.op_sum = '0;
        ack_off = 0; resp_delay = 0;
        #23;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_op_req", opif.op_req, 0);
        chk("rst_result", result, 0);
        chk("rst_result_inf", result_inf, 0);
        rst_n = 1'b1;

        // k = 0: every bit skipped, 3 cycles per bit plus DONE.
        kick(7'd0, 14'h0A55); wait_done(0, cyc);
        chk("k0_cycles", cyc, 22);
        chk("k0_reqs", req_cnt, 0);
        chk("k0_inf", result_inf, 1);
        @(negedge clk);
        chk("k0_busy_after", busy, 0);

        kick(7'd1, 14'h0A55); wait_done(0, cyc);
        chk("k1_cycles", cyc, 22);
        chk("k1_reqs", req_cnt, 0);
        chk("k1_result", result, 14'h0A55);
        chk("k1_inf", result_inf, 0);

        resp_delay = 3; resp_q = '{14'h1234};
        kick(7'd2, 14'h0A55); wait_done(0, cyc);
        chk("k2_cycles", cyc, 26);
        chk("k2_reqs", req_cnt, 1);
        chk("k2_dbl", req_dbl[0], 1);
        chk("k2_op_a", req_a[0], 14'h0A55);
        chk("k2_op_b", req_b[0], 14'h0A55);
        chk("k2_result", result, 14'h1234);
        chk("k2_inf", result_inf, 0);
        chk("k2_stable", stab_err, 0);

        // Doubling lands on -P, so the add collapses to infinity.
        resp_delay = 0; resp_q = '{14'h0A41};
        kick(7'd3, 14'h0A55); wait_done(0, cyc);
        chk("k3neg_reqs", req_cnt, 1);
        chk("k3neg_inf", result_inf, 1);

        resp_q = '{14'h1234, 14'h0777};
        kick(7'd3, 14'h0A55); wait_done(0, cyc);
        chk("k3_cycles", cyc, 24);
        chk("k3_reqs", req_cnt, 2);
        chk("k3_add_dbl", req_dbl[1], 0);
        chk("k3_add_a", req_a[1], 14'h1234);
        chk("k3_add_b", req_b[1], 14'h0A55);
        chk("k3_result", result, 14'h0777);
        chk("k3_inf", result_inf, 0);

        kick(7'd2, 14'h0055); wait_done(1, cyc);
        chk("x0_cycles", cyc, 22);
        chk("x0_reqs", req_cnt, 0);
        chk("x0_inf", result_inf, 1);

        // Watchdog: 64 request cycles, then DONE with error.
        ack_off = 1;
        kick(7'd2, 14'h0A55); wait_done(0, cyc);
        chk("wd_error", error, 1);
        chk("wd_inf", result_inf, 1);
        chk("wd_req_cycles", req_hi, 64);
        chk("wd_cycles", cyc, 84);
        ack_off = 0;
        kick(7'd1, 14'h0A55); wait_done(0, cyc);
        chk("wd_error_clr", error, 0);
        chk("wd_next_result", result, 14'h0A55);

        // Async reset while parked in DBL_WAIT.
        ack_off = 1;
        kick(7'd2, 14'h0A55);
        for (int c = 0; c < 100 && !opif.op_req; c++) @(negedge clk);
        chk("rst_mid_req_seen", opif.op_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_op_req", opif.op_req, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        #7 rst_n = 1'b1;
        ack_off = 0; resp_delay = 1; resp_q = '{14'h1234};
        kick(7'd2, 14'h0A55); wait_done(0, cyc);
        chk("rst_rerun_cycles", cyc, 24);
        chk("rst_rerun_result", result, 14'h1234);
        chk("rst_rerun_error", error, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
